// File: rtl/csi2_arb_pkg.sv
// csi2_arb_pkg: shared FSM states, channel-width defaults and one-hot helper for the CSI-2 header arbiter
package csi2_arb_pkg;
  typedef enum logic [1:0] {IDLE, GRANT, GAP} arb_state_t;
  localparam int CH_W = 2;
  localparam int NUM_CH_DFLT = 4;
  function automatic logic [3:0] onehot(input logic [1:0] ch);
    return 4'b0001 << ch;
  endfunction
endpackage

// File: rtl/csi2_rr_pick.sv
// csi2_rr_pick: combinational round-robin picker; ports: req (N requests), ptr (search start), valid (any request), idx (first request at or above ptr, wrapping at N)
module csi2_rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);
  always_comb begin
    logic [W-1:0] c;
    c = '0;
    valid = |req;
    idx = '0;
    // descending offsets so the candidate closest to ptr is assigned last and wins
    for (int i = N - 1; i >= 0; i--) begin
      c = W'((int'(ptr) + i) % N);
      if (req[c]) idx = c;
    end
  end
endmodule

// File: rtl/csi2_hdr_arbiter.sv
// csi2_hdr_arbiter: round-robin grant of the CSI-2 TX header path to NUM_CH buffers, with inter-packet gap; optional watchdog under CSI2_ARB_TIMEOUT_EN
// Ports: tx_clk_i clock; reset_tx_i async active-high reset; c2d_hs_rdy_i HS path ready; hdr_req_i level requests;
//        hdr_xfrdone_i completion pulses; arb_rdy_o idle-and-ready; arb_gnt_o one-hot grant; arb_ch_o granted index;
//        arb_busy_o GRANT/GAP; arb_timeout_o sticky watchdog flag (CSI2_ARB_TIMEOUT_EN only)
module csi2_hdr_arbiter import csi2_arb_pkg::*; #(
  parameter int NUM_CH = NUM_CH_DFLT,
  parameter int CH_W = csi2_arb_pkg::CH_W,
  parameter int GAP_CYC = 2
`ifdef CSI2_ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic              tx_clk_i,
  input  logic              reset_tx_i,
  input  logic              c2d_hs_rdy_i,
  input  logic [NUM_CH-1:0] hdr_req_i,
  input  logic [NUM_CH-1:0] hdr_xfrdone_i,
  output logic              arb_rdy_o,
  output logic [NUM_CH-1:0] arb_gnt_o,
  output logic [CH_W-1:0]   arb_ch_o,
  output logic              arb_busy_o
`ifdef CSI2_ARB_TIMEOUT_EN
  , output logic            arb_timeout_o
`endif
);
  arb_state_t state, state_n;
  logic [CH_W-1:0] rr_ptr, pick_idx;
  logic [3:0] gap_cnt, pick_oh;
  logic pick_valid, done, tmo;
  csi2_rr_pick #(.N(NUM_CH), .W(CH_W)) u_pick (
    .req(hdr_req_i), .ptr(rr_ptr), .valid(pick_valid), .idx(pick_idx)
  );
  assign pick_oh = onehot(2'(pick_idx));
  assign done = |(hdr_xfrdone_i & arb_gnt_o);
  assign arb_busy_o = state != IDLE;
`ifdef CSI2_ARB_TIMEOUT_EN
  logic [15:0] wd;
  assign tmo = state == GRANT && wd == 16'(TIMEOUT_CYC - 1);
`else
  assign tmo = 1'b0;
`endif
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = c2d_hs_rdy_i && pick_valid ? GRANT : IDLE;
      GRANT:   state_n = done || tmo ? (GAP_CYC == 0 ? IDLE : GAP) : GRANT;
      GAP:     state_n = gap_cnt <= 4'd1 ? IDLE : GAP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge tx_clk_i or posedge reset_tx_i) begin
    if (reset_tx_i) begin
      state <= IDLE;
      arb_rdy_o <= 1'b0;
      arb_gnt_o <= '0;
      arb_ch_o <= '0;
      rr_ptr <= '0;
      gap_cnt <= '0;
    end else begin
      state <= state_n;
      arb_rdy_o <= state_n == IDLE && c2d_hs_rdy_i;
      if (state == IDLE && state_n == GRANT) begin
        arb_gnt_o <= pick_oh[NUM_CH-1:0];
        arb_ch_o <= pick_idx;
        rr_ptr <= pick_idx == CH_W'(NUM_CH - 1) ? '0 : pick_idx + 1'b1;
      end
      if (state == GRANT && state_n != GRANT) begin
        arb_gnt_o <= '0;
        gap_cnt <= 4'(GAP_CYC);
      end
      if (state == GAP) gap_cnt <= gap_cnt - 1'b1;
    end
  end
`ifdef CSI2_ARB_TIMEOUT_EN
  always_ff @(posedge tx_clk_i or posedge reset_tx_i) begin
    if (reset_tx_i) begin
      wd <= '0;
      arb_timeout_o <= 1'b0;
    end else begin
      wd <= state == GRANT ? wd + 1'b1 : '0;
      if (tmo) arb_timeout_o <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_csi2_hdr_arbiter.sv
// tb_csi2_hdr_arbiter: directed self-checking bench for csi2_hdr_arbiter (NUM_CH=4, GAP_CYC=2)
module tb_csi2_hdr_arbiter;
  logic clk = 0, rst = 1, hs_rdy = 0;
  logic [3:0] req = 0, xfr = 0, gnt;
  logic [1:0] ch;
  logic rdy, busy;
  int n_chk = 0, n_fail = 0;
`ifdef CSI2_ARB_TIMEOUT_EN
  logic tmo;
  csi2_hdr_arbiter #(.NUM_CH(4), .CH_W(2), .GAP_CYC(2), .TIMEOUT_CYC(20)) dut (
    .tx_clk_i(clk), .reset_tx_i(rst), .c2d_hs_rdy_i(hs_rdy), .hdr_req_i(req), .hdr_xfrdone_i(xfr),
    .arb_rdy_o(rdy), .arb_gnt_o(gnt), .arb_ch_o(ch), .arb_busy_o(busy), .arb_timeout_o(tmo));
`else
  csi2_hdr_arbiter #(.NUM_CH(4), .CH_W(2), .GAP_CYC(2)) dut (
    .tx_clk_i(clk), .reset_tx_i(rst), .c2d_hs_rdy_i(hs_rdy), .hdr_req_i(req), .hdr_xfrdone_i(xfr),
    .arb_rdy_o(rdy), .arb_gnt_o(gnt), .arb_ch_o(ch), .arb_busy_o(busy));
`endif
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset(input logic rdy_in);
    req = 0;
    xfr = 0;
    hs_rdy = rdy_in;
    rst = 1;
    tick;
    rst = 0;
  endtask
  task automatic test_reset;
    do_reset(1'b1);
    rst = 1;
    #1;
    n_chk++; if (gnt !== 4'b0) begin n_fail++; $display("FAIL reset_gnt got %b want 0000", gnt); end
    n_chk++; if (ch !== 2'd0) begin n_fail++; $display("FAIL reset_ch got %0d want 0", ch); end
    n_chk++; if (rdy !== 1'b0) begin n_fail++; $display("FAIL reset_rdy got %b want 0", rdy); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef CSI2_ARB_TIMEOUT_EN
    n_chk++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL reset_tmo got %b want 0", tmo); end
`endif
    tick;
    rst = 0;
    tick;
    n_chk++; if (rdy !== 1'b1) begin n_fail++; $display("FAIL idle_rdy got %b want 1", rdy); end
  endtask
  task automatic test_basic;
    do_reset(1'b1);
    req = 4'b0101;
    tick;
    n_chk++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL basic_gnt0 got %b want 0001", gnt); end
    n_chk++; if (busy !== 1'b1 || rdy !== 1'b0) begin n_fail++; $display("FAIL basic_busy got busy=%b rdy=%b want 1 0", busy, rdy); end
    repeat (2) tick;
    xfr = 4'b0001;
    tick;
    xfr = 0;
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL basic_drop got %b want 0000", gnt); end
    for (int i = 1; i <= 3; i++) begin
      tick;
      if (i < 3) begin
        n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL basic_gap%0d got %b want 0000", i, gnt); end
      end else begin
        n_chk++; if (gnt !== 4'b0100 || ch !== 2'd2) begin n_fail++; $display("FAIL basic_gnt2 got %b ch %0d want 0100 ch 2", gnt, ch); end
      end
    end
  endtask
  task automatic test_rotate;
    do_reset(1'b1);
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      int k;
      logic [3:0] eg;
      k = 0;
      eg = 4'(1 << (i % 4));
      while (gnt === 4'b0 && k < 8) begin tick; k++; end
      n_chk++; if (gnt !== eg) begin n_fail++; $display("FAIL rotate_gnt%0d got %b want %b", i, gnt, eg); end
      n_chk++; if (ch !== 2'(i % 4)) begin n_fail++; $display("FAIL rotate_ch%0d got %0d want %0d", i, ch, i % 4); end
      repeat (3) tick;
      xfr = eg;
      tick;
      xfr = 0;
    end
  endtask
  task automatic test_hs_rdy;
    int bad;
    do_reset(1'b0);
    req = 4'b0010;
    bad = 0;
    repeat (10) begin
      tick;
      if (gnt !== 4'b0 || rdy !== 1'b0) bad++;
    end
    n_chk++; if (bad != 0) begin n_fail++; $display("FAIL hsrdy_hold got %0d bad cycles (gnt=%b rdy=%b) want 0", bad, gnt, rdy); end
    hs_rdy = 1;
    tick;
    n_chk++; if (gnt !== 4'b0010 || ch !== 2'd1) begin n_fail++; $display("FAIL hsrdy_gnt got %b ch %0d want 0010 ch 1", gnt, ch); end
  endtask
  task automatic test_other_done;
    do_reset(1'b1);
    req = 4'b0100;
    tick;
    n_chk++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL other_gnt got %b want 0100", gnt); end
    req = 0;
    xfr = 4'b0010;
    tick;
    xfr = 0;
    repeat (3) tick;
    n_chk++; if (gnt !== 4'b0100 || busy !== 1'b1) begin n_fail++; $display("FAIL other_hold got %b busy %b want 0100 1", gnt, busy); end
    xfr = 4'b0100;
    tick;
    xfr = 0;
    n_chk++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL other_drop got %b want 0000", gnt); end
  endtask
  task automatic test_reset_mid;
    do_reset(1'b1);
    req = 4'b1000;
    tick;
    n_chk++; if (gnt !== 4'b1000 || ch !== 2'd3) begin n_fail++; $display("FAIL mid_gnt got %b ch %0d want 1000 ch 3", gnt, ch); end
    #2 rst = 1;
    #1;
    n_chk++; if (gnt !== 4'b0 || ch !== 2'd0 || busy !== 1'b0 || rdy !== 1'b0) begin n_fail++; $display("FAIL mid_async got gnt=%b ch=%0d busy=%b rdy=%b want all 0", gnt, ch, busy, rdy); end
    req = 4'b1111;
    #1 rst = 0;
    tick;
    n_chk++; if (gnt !== 4'b0001 || ch !== 2'd0) begin n_fail++; $display("FAIL mid_first got %b ch %0d want 0001 ch 0", gnt, ch); end
  endtask
`ifdef CSI2_ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset(1'b1);
    req = 4'b0001;
    tick;
    repeat (19) tick;
    n_chk++; if (gnt !== 4'b0001 || tmo !== 1'b0) begin n_fail++; $display("FAIL tmo_before got %b tmo %b want 0001 0", gnt, tmo); end
    tick;
    n_chk++; if (gnt !== 4'b0000 || tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_fire got %b tmo %b want 0000 1", gnt, tmo); end
    req = 0;
    repeat (6) tick;
    n_chk++; if (tmo !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky got %b want 1", tmo); end
  endtask
`endif
  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset;
    test_basic;
    test_rotate;
    test_hs_rdy;
    test_other_done;
    test_reset_mid;
`ifdef CSI2_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/csi2_hdr_arbiter.md
Name: csi2_hdr_arbiter

Overview:
Round-robin arbiter that shares the single CSI-2 TX packet-header/payload path between NUM_CH per-channel header buffers in the 4-to-1 aggregator. It collects each buffer's hdr_req and issues one-hot arb_gnt. It holds the grant until the granted buffer signals hdr_xfrdone, then enforces an inter-packet gap. It runs entirely in the TX clock domain.

Parameters:
NUM_CH, 4, number of requesting header buffers (2..4)
CH_W, 2, width of the channel index; must satisfy 2**CH_W >= NUM_CH
GAP_CYC, 2, idle cycles forced after each hdr_xfrdone before the next grant (0..15)
TIMEOUT_CYC, 65535, watchdog limit in tx_clk cycles; used only with CSI2_ARB_TIMEOUT_EN

Ports:
tx_clk_i  in  1  TX byte clock; the only clock
reset_tx_i  in  1  asynchronous, active-high reset
c2d_hs_rdy_i  in  1  HS TX path ready to accept a new packet
hdr_req_i  in  NUM_CH  per-buffer header request, level
hdr_xfrdone_i  in  NUM_CH  per-buffer transfer-complete pulse, 1 cycle
arb_rdy_o  out  1  arbiter idle and able to grant (IDLE state and c2d_hs_rdy_i)
arb_gnt_o  out  NUM_CH  one-hot grant, registered
arb_ch_o  out  CH_W  index of the granted channel; valid while arb_gnt_o != 0
arb_busy_o  out  1  high in GRANT and GAP states
arb_timeout_o  out  1  sticky watchdog flag; present only with CSI2_ARB_TIMEOUT_EN

Behaviour:
- Reset (asynchronous, any state) forces:
  - state = IDLE
  - arb_gnt_o = 0, arb_ch_o = 0, arb_rdy_o = 0, arb_busy_o = 0, arb_timeout_o = 0
  - rr_ptr = 0, gap_cnt = 0
- arb_rdy_o is registered. It is 1 in IDLE when c2d_hs_rdy_i was 1 on the previous cycle.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - If c2d_hs_rdy_i=1 and |hdr_req_i, pick the first requesting channel searching upward from rr_ptr with wrap.
  - On the next edge: arb_gnt_o = onehot(ch), arb_ch_o = ch, rr_ptr = (ch+1) mod NUM_CH, state -> GRANT.
  - Grant latency is 1 cycle from the sampled request.
  - If c2d_hs_rdy_i=0, requests are ignored and the FSM stays in IDLE.
- GRANT:
  - Grant is held stable. Deasserting hdr_req_i does not revoke it.
  - hdr_xfrdone_i[ch] for the granted ch: arb_gnt_o -> 0 on the next edge; state -> GAP with gap_cnt = GAP_CYC, or -> IDLE if GAP_CYC = 0.
  - hdr_xfrdone_i on any non-granted channel is ignored.
- GAP:
  - gap_cnt decrements each cycle; at 1 the state -> IDLE.
  - Requests are not sampled during GAP.
  - Total gap between grant drop and earliest new grant is GAP_CYC+1 cycles.
- Fairness: with all channels requesting continuously, grants rotate 0,1,2,3,0... No channel waits more than NUM_CH-1 grants.
- Simultaneous xfrdone and new request on the same cycle: the request is not granted until after GAP.
- Request bits at index >= NUM_CH do not exist. rr_ptr wraps at NUM_CH, not at 2**CH_W.

Optional Feature:
CSI2_ARB_TIMEOUT_EN:
- Defined: a 16-bit watchdog counts cycles in GRANT.
  - On reaching TIMEOUT_CYC without hdr_xfrdone: grant is forcibly released, state -> GAP, arb_timeout_o sets.
  - arb_timeout_o stays set until reset.
  - The counter clears on entry to GRANT.
- Undefined: no counter and no arb_timeout_o port; GRANT waits indefinitely.

Decomposition:
- Shared package csi2_arb_pkg:
  - state enum (IDLE, GRANT, GAP)
  - CH_W, default NUM_CH
  - a function onehot(ch)
- One sub-module: csi2_rr_pick. Combinational round-robin priority picker with inputs req and ptr, outputs valid and idx. The FSM and counters stay in the top level.

Test Plan:
1. Reset and req=4'b0101, hs_rdy=1: gnt=0001 at cycle 1; after xfrdone[0], gnt=0 next cycle; gnt=0100 exactly 3 cycles after the drop (GAP_CYC=2).
2. All req=1111 held, xfrdone pulsed 4 cycles after each grant: grant sequence 0,1,2,3,0; arb_ch_o matches each grant.
3. hs_rdy=0 with req=0010 for 10 cycles: gnt stays 0 and arb_rdy=0. Raise hs_rdy: gnt=0010 one cycle later.
4. Grant to ch2, then req[2] dropped and xfrdone[1] pulsed: gnt stays 0100 until xfrdone[2].
5. Reset asserted mid-GRANT on ch3: all outputs 0 immediately; after release with req=1111, first grant is ch0.
6. With CSI2_ARB_TIMEOUT_EN and TIMEOUT_CYC=20, no xfrdone: gnt drops at cycle 20 of GRANT, arb_timeout_o=1 and stays 1.
